cfg_chain_loader: RTL and testbench

Upstream feeder for the cell configuration chain. Takes 3-bit cell symbols from a valid/ready stream and shifts them MSB-first into the chain's serial input. Generates the chain's slow configuration clock from the single system clock. One frame of NCELLS symbols per start request; the first symbol accepted ends up in the cell farthest from the loader.

---
 rtl/morphle_pkg.sv | 31 +++
 rtl/cfg_phase_timer.sv | 41 ++++
 rtl/cfg_chain_loader.sv | 195 +++++++++++++++++++
 tb/tb_cfg_chain_loader.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morphle_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : morphle_pkg
//  Description : Shared definitions for the cell configuration chain.
//                - 3-bit cell symbol codes, shifted MSB first.
//                - State encoding of the chain loader FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
package morphle_pkg;

   // Cell symbol codes
   localparam logic [2:0] SYM_SPACE = 3'b000;
   localparam logic [2:0] SYM_PLUS  = 3'b001;
   localparam logic [2:0] SYM_MINUS = 3'b010;
   localparam logic [2:0] SYM_BAR   = 3'b011;
   localparam logic [2:0] SYM_ONE   = 3'b100;
   localparam logic [2:0] SYM_ZERO  = 3'b101;
   localparam logic [2:0] SYM_Y     = 3'b110;
   localparam logic [2:0] SYM_N     = 3'b111;

   // Loader FSM state encoding
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_SYM = 3'd1,
      ST_SETUP    = 3'd2,
      ST_HIGH     = 3'd3,
      ST_DONE     = 3'd4
   } loader_state_t;

endpackage : morphle_pkg
`default_nettype wire

// File: rtl/cfg_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : cfg_phase_timer
//  Description : Phase-length counter for the configuration clock. A load
//                pulse presets the counter to DIV-1; it then counts down to 0
//                and stays there. expire is high while the count is 0, so a
//                phase entered on a load edge lasts exactly DIV cycles.
//  Ports       : clk    - system clock
//                reset  - asynchronous active-high reset
//                load   - start a new DIV-cycle phase at the next edge
//                expire - current phase is in its last cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module cfg_phase_timer #(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic expire
);

   localparam int CW = $clog2(DIV + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= CW'(DIV - 1);
      end else if (count != '0) begin
         // Saturates at zero: no wrap once the phase has expired.
         count <= count - CW'(1);
      end
   end

   assign expire = (count == '0);

endmodule : cfg_phase_timer
`default_nettype wire

// File: rtl/cfg_chain_loader.sv
`default_nettype none
// ============================================================================
//  Module      : cfg_chain_loader
//  Description : Upstream feeder for the cell configuration chain. Accepts
//                3-bit symbols on a valid/ready stream and shifts each one
//                MSB first into the chain's serial input, generating the
//                slow configuration clock (confclk) from clk. One frame of
//                NCELLS symbols is loaded per start request; the first symbol
//                accepted ends up in the cell farthest from the loader.
//
//                Optional build macro CFG_CHAIN_READBACK_EN adds rb_sym /
//                rb_valid: cbitout is sampled just before every confclk rise
//                and each completed group of three bits is presented as one
//                symbol, so the previous chain contents emerge tail first.
//
//  Ports       : clk       - system clock
//                reset     - asynchronous active-high reset
//                start     - frame request, honoured only when idle
//                sym       - cell symbol, bit 2 shifted first
//                sym_valid - sym is valid
//                sym_ready - loader accepts sym this cycle
//                confclk   - chain configuration clock
//                cbitin    - serial data into the chain head
//                cbitout   - serial data returned from the chain tail
//                busy      - frame in progress
//                done      - one-cycle pulse at end of frame
//                rb_sym    - (readback build) symbol read out of the tail
//                rb_valid  - (readback build) rb_sym is valid this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module cfg_chain_loader
   import morphle_pkg::*;
#(
   parameter int NCELLS = 4,
   parameter int DIV    = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] sym,
   input  logic       sym_valid,
   output logic       sym_ready,
   output logic       confclk,
   output logic       cbitin,
   input  logic       cbitout,
   output logic       busy,
   output logic       done
`ifdef CFG_CHAIN_READBACK_EN
   ,
   output logic [2:0] rb_sym,
   output logic       rb_valid
`endif
);

   localparam int CLW = $clog2(NCELLS + 1);

   loader_state_t  state;
   logic [CLW-1:0] cells_left;
   logic [1:0]     bit_idx;
   logic [2:0]     sr;
   logic           phase_load;
   logic           phase_expire;

   // ------------------------------------------------------------------------
   // Phase timer: restarted on every edge that enters SETUP or HIGH, so that
   // each confclk low/high phase lasts DIV cycles. The WAIT_SYM part of the
   // low phase is not timed; it lasts as long as the stream stalls.
   // ------------------------------------------------------------------------
   always_comb begin
      phase_load = 1'b0;
      case (state)
         ST_WAIT_SYM: phase_load = sym_valid;
         ST_SETUP:    phase_load = phase_expire;
         ST_HIGH:     phase_load = phase_expire && (bit_idx != 2'd0);
         default:     phase_load = 1'b0;
      endcase
   end

   cfg_phase_timer #(
      .DIV (DIV)
   ) u_phase_timer (
      .clk    (clk),
      .reset  (reset),
      .load   (phase_load),
      .expire (phase_expire)
   );

   // ------------------------------------------------------------------------
   // Loader FSM. All outputs are registered and updated on the transition
   // into the state that defines them, so they are valid for the whole state.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         confclk    <= 1'b0;
         cbitin     <= 1'b0;
         sym_ready  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cells_left <= '0;
         bit_idx    <= 2'd0;
         sr         <= 3'd0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  cells_left <= CLW'(NCELLS);
                  busy       <= 1'b1;
                  sym_ready  <= 1'b1;
                  state      <= ST_WAIT_SYM;
               end
            end

            ST_WAIT_SYM: begin
               if (sym_valid) begin
                  sr        <= sym;
                  bit_idx   <= 2'd2;
                  // Present the MSB from the first SETUP cycle onwards.
                  cbitin    <= sym[2];
                  sym_ready <= 1'b0;
                  state     <= ST_SETUP;
               end
            end

            ST_SETUP: begin
               if (phase_expire) begin
                  confclk <= 1'b1;
                  state   <= ST_HIGH;
               end
            end

            ST_HIGH: begin
               if (phase_expire) begin
                  confclk <= 1'b0;
                  if (bit_idx != 2'd0) begin
                     bit_idx <= bit_idx - 2'd1;
                     cbitin  <= sr[bit_idx - 2'd1];
                     state   <= ST_SETUP;
                  end else if (cells_left > CLW'(1)) begin
                     cells_left <= cells_left - CLW'(1);
                     sym_ready  <= 1'b1;
                     state      <= ST_WAIT_SYM;
                  end else begin
                     done   <= 1'b1;
                     busy   <= 1'b0;
                     cbitin <= 1'b0;
                     state  <= ST_DONE;
                  end
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef CFG_CHAIN_READBACK_EN
   // ------------------------------------------------------------------------
   // Readback: the tail bit is sampled in the last SETUP cycle, i.e. just
   // before confclk rises and the chain shifts it away. After the third
   // HIGH phase of a symbol the three sampled bits form one tail symbol.
   // ------------------------------------------------------------------------
   logic [2:0] rb_sh;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rb_sh    <= 3'd0;
         rb_sym   <= 3'd0;
         rb_valid <= 1'b0;
      end else begin
         rb_valid <= 1'b0;
         if (state == ST_SETUP && phase_expire) begin
            rb_sh <= {rb_sh[1:0], cbitout};
         end
         if (state == ST_HIGH && phase_expire && bit_idx == 2'd0) begin
            rb_sym   <= rb_sh;
            rb_valid <= 1'b1;
         end
      end
   end
`else
   // Readback hardware is absent; the chain return path is left unloaded.
   logic unused_cbitout;
   assign unused_cbitout = cbitout;
`endif

endmodule : cfg_chain_loader
`default_nettype wire

// File: tb/tb_cfg_chain_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cfg_chain_loader
//  Description : Self-checking bench for cfg_chain_loader. A driver issues
//                frames of random symbols with random stream stalls, pushes
//                the expected serial bits, done cycle, final chain contents
//                and (readback build) tail symbols into queues; a monitor
//                pops and compares as the DUT produces them. A behavioural
//                chain (3*NCELLS-bit shift register clocked by confclk)
//                closes the loop through cbitout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cfg_chain_loader;
   import morphle_pkg::*;

   localparam int NC      = 3;
   localparam int DV      = 2;
   localparam int NB      = 3 * NC;
   localparam int SYM_CYC = 6 * DV + 1;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start;
   logic [2:0] sym;
   logic       sym_valid;
   logic       sym_ready;
   logic       confclk;
   logic       cbitin;
   logic       cbitout;
   logic       busy;
   logic       done;
`ifdef CFG_CHAIN_READBACK_EN
   logic [2:0] rb_sym;
   logic       rb_valid;
`endif

   cfg_chain_loader #(
      .NCELLS (NC),
      .DIV    (DV)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .sym       (sym),
      .sym_valid (sym_valid),
      .sym_ready (sym_ready),
      .confclk   (confclk),
      .cbitin    (cbitin),
      .cbitout   (cbitout),
      .busy      (busy),
      .done      (done)
`ifdef CFG_CHAIN_READBACK_EN
      ,
      .rb_sym    (rb_sym),
      .rb_valid  (rb_valid)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural configuration chain: head bit 0, tail bit NB-1.
   logic [NB-1:0] chain;
   always @(posedge confclk) chain <= {chain[NB-2:0], cbitin};
   assign cbitout = chain[NB-1];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int frames_done = 0;

   logic          exp_bits[$];
   int            exp_done[$];
   logic [NB-1:0] exp_chain_q[$];
   logic [2:0]    exp_rb[$];
   logic [NB-1:0] cur_exp;
   logic [NB-1:0] preload;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // ------------------------------------------------------------------------
   // Monitor
   // ------------------------------------------------------------------------
   logic prev_cc, prev_cb;
   int   hi_len, lo_len, rises;

   initial begin
      logic          b;
      int            dc;
      logic [NB-1:0] ec;
      logic [2:0]    er;
      prev_cc = 1'b0; prev_cb = 1'b0; hi_len = 0; lo_len = DV; rises = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_cc = 1'b0; prev_cb = 1'b0; hi_len = 0; lo_len = DV; rises = 0;
         end else begin
            if (confclk && !prev_cc) begin
               check("low_phase_min", 32'(lo_len >= DV), 32'd1);
               check("cbitin_stable_at_rise", cbitin, prev_cb);
               if (exp_bits.size() == 0) fail_now("unexpected_confclk_rise");
               else begin
                  b = exp_bits.pop_front();
                  check("cbitin_bit", cbitin, b);
               end
               rises++;
               hi_len = 1;
            end else if (confclk) begin
               check("cbitin_stable_high", cbitin, prev_cb);
               hi_len++;
            end else if (prev_cc) begin
               check("high_phase_len", hi_len, DV);
               lo_len = 1;
            end else begin
               lo_len++;
            end

            if (done) begin
               done_cnt++;
               if (exp_done.size() == 0) fail_now("unexpected_done");
               else begin
                  dc = exp_done.pop_front();
                  check("done_cycle", cyc, dc);
               end
               check("rises_per_frame", rises, NB);
               check("busy_at_done", busy, 1'b0);
               check("cbitin_at_done", cbitin, 1'b0);
               if (exp_chain_q.size() == 0) fail_now("no_chain_expectation");
               else begin
                  ec = exp_chain_q.pop_front();
                  check("chain_contents", chain, ec);
               end
               rises = 0;
            end
`ifdef CFG_CHAIN_READBACK_EN
            if (rb_valid) begin
               if (exp_rb.size() == 0) fail_now("unexpected_rb_valid");
               else begin
                  er = exp_rb.pop_front();
                  check("rb_sym", rb_sym, er);
               end
            end
`endif
            prev_cc = confclk;
            prev_cb = cbitin;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Driver: one frame. gap = stall cycles per symbol (or max if rand_gap),
   // abort = reset during HIGH of the second bit, poke = start while busy.
   // ------------------------------------------------------------------------
   task automatic run_frame(input int gap, input bit rand_gap, input bit abort,
                            input bit poke, input bit use_forced,
                            input logic [NB-1:0] forced);
      logic [2:0]    syms[NC];
      int            gaps[NC];
      int            gsum, k, g, it, e_s, drises;
      logic [NB-1:0] pre, post;
      logic          pcc;
      bit            poked;
      gsum = 0;
      pre  = cur_exp;
      post = '0;
      for (int i = 0; i < NC; i++) begin
         syms[i] = use_forced ? forced[NB-1-3*i -: 3] : 3'($urandom_range(0, 7));
         gaps[i] = rand_gap ? int'($urandom_range(0, gap)) : gap;
         gsum   += gaps[i];
         post    = {post[NB-4:0], syms[i]};
         exp_bits.push_back(syms[i][2]);
         exp_bits.push_back(syms[i][1]);
         exp_bits.push_back(syms[i][0]);
      end
      if (!abort) begin
         exp_chain_q.push_back(post);
`ifdef CFG_CHAIN_READBACK_EN
         for (int c = NC - 1; c >= 0; c--) exp_rb.push_back(pre[3*c+2 -: 3]);
`endif
      end

      @(negedge clk);
      check("busy_before_start", busy, 1'b0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      e_s   = cyc;
      check("busy_after_start", busy, 1'b1);
      if (!abort) begin
         exp_done.push_back(e_s + NC * SYM_CYC + gsum);
         cur_exp = post;
      end

      k = 0; g = gaps[0]; it = 0; drises = 0; pcc = 1'b0; poked = 1'b0;
      while (k < NC) begin
         if (confclk && !pcc) drises++;
         pcc = confclk;
         if (abort && confclk && drises == 2) begin
            #1 reset = 1'b1;
            #1;
            check("abort_confclk_low", confclk, 1'b0);
            check("abort_cbitin_low", cbitin, 1'b0);
            exp_bits.delete();
            exp_chain_q.delete();
            exp_rb.delete();
            cur_exp = {pre[NB-3:0], syms[0][2], syms[0][1]};
            sym_valid = 1'b0;
            start = 1'b0;
            @(negedge clk);
            @(negedge clk);
            #1 reset = 1'b0;
            @(negedge clk);
            check("abort_busy_cleared", busy, 1'b0);
            check("abort_chain_partial", chain, cur_exp);
            return;
         end
         start = 1'b0;
         if (sym_ready) begin
            if (g == 0) begin
               sym = syms[k]; sym_valid = 1'b1; k++;
               if (k < NC) g = gaps[k];
            end else begin
               sym = 3'($urandom_range(0, 7)); sym_valid = 1'b0; g--;
            end
         end else begin
            sym_valid = 1'b0;
            if (poke && !poked && k == 1) begin start = 1'b1; poked = 1'b1; end
         end
         @(negedge clk);
         it++;
         if (it > 2000) begin fail_now("symbol_stream_timeout"); k = NC; end
      end
      sym_valid = 1'b0;
      start = 1'b0;
      it = 0;
      while (exp_done.size() != 0 && it < 400) begin
         @(negedge clk);
         it++;
      end
      if (exp_done.size() != 0) begin
         fail_now("done_timeout");
         exp_done.delete();
      end
      frames_done++;
   endtask

   // ------------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------------
   initial begin
      start = 1'b0; sym = 3'd0; sym_valid = 1'b0;
      for (int c = 0; c < NC; c++) preload[3*c +: 3] = 3'($urandom_range(0, 7));
      preload[NB-1 -: 3] = SYM_ZERO;
      preload[2:0]       = SYM_MINUS;
      chain   <= preload;
      cur_exp  = preload;

      #2 reset = 1'b1;
      #1;
      check("reset_confclk", confclk, 1'b0);
      check("reset_cbitin", cbitin, 1'b0);
      check("reset_sym_ready", sym_ready, 1'b0);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      repeat (3) @(negedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("idle_sym_ready", sym_ready, 1'b0);
      check("idle_busy", busy, 1'b0);
`ifdef CFG_CHAIN_READBACK_EN
      check("reset_rb_valid", rb_valid, 1'b0);
      check("reset_rb_sym", rb_sym, 3'd0);
`endif

      run_frame(0, 1'b0, 1'b0, 1'b0, 1'b1, {SYM_N, SYM_SPACE, SYM_PLUS});
      run_frame(10, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      run_frame(0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      run_frame(0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
      run_frame(0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      for (int f = 0; f < 6; f++)
         run_frame(4, 1'b1, 1'b0, ($urandom_range(0, 1) == 1), 1'b0, '0);

      repeat (5) @(negedge clk);
      check("done_pulse_count", done_cnt, frames_done);
      check("leftover_bits", exp_bits.size(), 0);
      check("leftover_rb", exp_rb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (failures so far %0d)", n_fail);
      $fatal(1, "watchdog");
   end

endmodule : tb_cfg_chain_loader
`default_nettype wire
